control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Hardwired control unit that sits directly upstream of DataPath and drives every control input the datapath exposes.
- After each fetch it decodes the instruction register's opcode and steps through a fixed per-instruction T-state sequence.
- It replaces hand-driven testbench control with a Moore FSM that supports fetch, ld, ldi, st, R-type ALU, I-type ALU, br, jr, nop and halt.

Parameters:
OPW, 5, opcode width; opcode is IR[31:27]
ADD_CODE, 5'b00011, aluControl value used for address and offset arithmetic

Ports:
clock  in  1  system clock
clear  in  1  asynchronous active-low reset
IR  in  32  instruction register contents from DataPath
CON  in  1  branch condition flag from the CON FF
stop  in  1  request to halt at the next instruction boundary
run  out  1  high while executing; low in RESET and HALT
PCout, IncPC, MARin, PCin, MDRin, MDRout, IRin, Yin, ZLOin, ZLOout, Cout  out  1 each  datapath register strobes
read, write, RAMenable  out  1 each  memory controls
Gra, Grb, Grc, Rin, Rout, BAout, conin  out  1 each  register-select and CON controls
ZMuxEnable, ZSelect, ZMuxOut  out  1 each  Z mux controls
aluControl  out  5  ALU operation code

Behaviour:
- Clocking: state register updates on the falling edge of clock. All outputs are a pure decode of state, so they are stable across the datapath's rising edge. Each state lasts exactly one clock.
- Reset: clear low forces state RESET asynchronously. In RESET all outputs are 0 and aluControl=0. On the first falling edge after clear rises, the FSM moves to T0. Asserting clear mid-instruction abandons that instruction immediately.
- Default: any strobe not listed for a state is 0. aluControl=0 unless listed.
- Opcodes: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, andi=01101, ori=01110, br=10010, jr=10100, nop=11010, halt=11011. Any other opcode executes as nop.
- Fetch:
  - T0: PCout, MARin, IncPC.
  - T1: read, RAMenable, MDRin.
  - T2: MDRout, IRin.
  - After T2 the FSM branches on IR[31:27], sampled on the falling edge that ends T2.
- ldi: T3 Grb,BAout,Yin; T4 Cout,ZLOin,aluControl=ADD_CODE; T5 ZMuxEnable,ZMuxOut,ZSelect=0,Gra,Rin.
- ld: T3/T4 as ldi; T5 ZLOout,MARin; T6 read,RAMenable,MDRin; T7 MDRout,Gra,Rin.
- st: T3/T4 as ldi; T5 ZLOout,MARin; T6 Gra,Rout,MDRin (read=0 selects bus); T7 write,RAMenable.
- R-type (add/sub/and/or): T3 Grb,Rout,Yin; T4 Grc,Rout,ZLOin,aluControl=opcode; T5 ZLOout,Gra,Rin.
- I-type: T3 Grb,Rout,Yin; T4 Cout,ZLOin, with aluControl = 00011 for addi, 00101 for andi, 00110 for ori; T5 ZLOout,Gra,Rin.
- br:
  - T3 Gra,Rout,conin.
  - T4 PCout,Yin.
  - T5 Cout,ZLOin,aluControl=ADD_CODE.
  - T6: if CON=1, ZLOout,PCin; otherwise no strobes. CON is sampled combinationally during T6.
- jr: T3 Gra,Rout,PCin.
- nop: no T3. The FSM returns to T0 directly after T2.
- Instruction end: after the last T-state the FSM returns to T0. If stop=1 on that falling edge it enters HALT instead.
- halt opcode: after T2 the FSM enters HALT.
- HALT: all outputs 0 and run=0. Only clear exits HALT.
- stop is ignored mid-instruction and only acts at a boundary.
- run is 1 in every state except RESET and HALT.
- Never assert read and write in the same state. Never assert two bus drivers in the same state; the drivers are PCout, MDRout, ZLOout, Rout, BAout, Cout and ZMuxOut.

Test Plan:
- Reset: hold clear=0 for 3 clocks → all outputs 0, run=0; release → T0 decode (PCout=MARin=IncPC=1) on next falling edge, run=1.
- ldi (IR=32'h0880_0005): T0..T5 strobes exactly as specified, T4 aluControl=00011 with Cout=1, ZLOin=1; T6 equals T0.
- ld then st: ld takes 8 states with T7 MDRout,Gra,Rin; st T7 has write=1,RAMenable=1,read=0; no bus-driver overlap in any state.
- add (opcode 00011): T4 aluControl=00011 with Grc,Rout; sub (00100) gives aluControl=00100; andi gives 00101.
- br with CON=1 → T6 ZLOout=PCin=1; repeat with CON=0 → T6 all strobes 0, next state T0.
- Halt paths: halt opcode → HALT after T2, run=0. stop=1 raised during T4 of add → completes T5, then HALT. clear pulsed mid-ld T6 → immediate RESET outputs.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for DataPath.
// After each fetch (T0..T2) it branches on the IR opcode and steps through a
// fixed T-state sequence per instruction class: ld, ldi, st, R-type ALU,
// I-type ALU, br, jr, nop and halt. Any opcode it does not recognise runs as nop.
//
// Ports:
//   clock       system clock; the state register updates on the falling edge
//   clear       asynchronous active-low reset (forces RESET)
//   IR          instruction register contents; the opcode is IR[31:27]
//   CON         branch condition flag, used combinationally in br T6
//   stop        halt request, honoured only at an instruction boundary
//   run         high in every state except RESET and HALT
//   PCout..Cout datapath register strobes
//   read, write, RAMenable                memory controls
//   Gra, Grb, Grc, Rin, Rout, BAout, conin register-select and CON controls
//   ZMuxEnable, ZSelect, ZMuxOut          Z mux controls
//   aluControl  ALU operation code
//   state_dbg   current FSM state, for observation only
//
// Handshake: none. Each state lasts exactly one clock. Every strobe is a
// registered decode of the state, so the strobes are stable across the
// datapath's rising edge. The one exception is br T6: there ZLOout and PCin
// are gated by CON combinationally.
module control_sequencer #(
   parameter int          OPW      = 5,
   parameter logic [4:0]  ADD_CODE = 5'b00011
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        CON,
   input  logic        stop,
   output logic        run,
   output logic        PCout,
   output logic        IncPC,
   output logic        MARin,
   output logic        PCin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        ZLOin,
   output logic        ZLOout,
   output logic        Cout,
   output logic        read,
   output logic        write,
   output logic        RAMenable,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        conin,
   output logic        ZMuxEnable,
   output logic        ZSelect,
   output logic        ZMuxOut,
   output logic [4:0]  aluControl,
   output logic [4:0]  state_dbg
);

   localparam logic [OPW-1:0] OP_LD   = 5'b00000;
   localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPW-1:0] OP_ST   = 5'b00010;
   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] OP_AND  = 5'b00101;
   localparam logic [OPW-1:0] OP_OR   = 5'b00110;
   localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPW-1:0] OP_BR   = 5'b10010;
   localparam logic [OPW-1:0] OP_JR   = 5'b10100;
   localparam logic [OPW-1:0] OP_HALT = 5'b11011;

   typedef enum logic [4:0] {
      S_RESET, S_HALT, S_T0, S_T1, S_T2,
      S_LDI_T3, S_LDI_T4, S_LDI_T5,
      S_LD_T3, S_LD_T4, S_LD_T5, S_LD_T6, S_LD_T7,
      S_ST_T3, S_ST_T4, S_ST_T5, S_ST_T6, S_ST_T7,
      S_R_T3, S_R_T4, S_R_T5,
      S_I_T3, S_I_T4, S_I_T5,
      S_BR_T3, S_BR_T4, S_BR_T5, S_BR_T6,
      S_JR_T3
   } state_t;

   typedef struct packed {
      logic run, pc_out, inc_pc, mar_in, pc_in, mdr_in, mdr_out, ir_in;
      logic y_in, zlo_in, zlo_out, c_out, read, write, ram_enable;
      logic gra, grb, grc, r_in, r_out, ba_out, con_in;
      logic zmux_enable, zselect, zmux_out;
      logic [4:0] alu;
   } ctrl_t;

   state_t         state_q, state_d;
   logic [OPW-1:0] op_q, op_d;
   ctrl_t          ctrl_q, ctrl_d;
   state_t         boundary;
   logic           br_take;
   logic           unused_ir;

   // Only the opcode field of IR is used here.
   assign unused_ir = ^IR[31-OPW:0];

   // Next state. The opcode is latched when leaving T2 so the ALU code
   // stays fixed for the whole instruction.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      boundary = stop ? S_HALT : S_T0;
      case (state_q)
         S_RESET:  state_d = S_T0;
         S_HALT:   state_d = S_HALT;
         S_T0:     state_d = S_T1;
         S_T1:     state_d = S_T2;
         S_T2: begin
            op_d = IR[31 -: OPW];
            case (IR[31 -: OPW])
               OP_LD:                          state_d = S_LD_T3;
               OP_LDI:                         state_d = S_LDI_T3;
               OP_ST:                          state_d = S_ST_T3;
               OP_ADD, OP_SUB, OP_AND, OP_OR:  state_d = S_R_T3;
               OP_ADDI, OP_ANDI, OP_ORI:       state_d = S_I_T3;
               OP_BR:                          state_d = S_BR_T3;
               OP_JR:                          state_d = S_JR_T3;
               OP_HALT:                        state_d = S_HALT;
               default:                        state_d = boundary; // nop
            endcase
         end
         S_LDI_T3: state_d = S_LDI_T4;
         S_LDI_T4: state_d = S_LDI_T5;
         S_LD_T3:  state_d = S_LD_T4;
         S_LD_T4:  state_d = S_LD_T5;
         S_LD_T5:  state_d = S_LD_T6;
         S_LD_T6:  state_d = S_LD_T7;
         S_ST_T3:  state_d = S_ST_T4;
         S_ST_T4:  state_d = S_ST_T5;
         S_ST_T5:  state_d = S_ST_T6;
         S_ST_T6:  state_d = S_ST_T7;
         S_R_T3:   state_d = S_R_T4;
         S_R_T4:   state_d = S_R_T5;
         S_I_T3:   state_d = S_I_T4;
         S_I_T4:   state_d = S_I_T5;
         S_BR_T3:  state_d = S_BR_T4;
         S_BR_T4:  state_d = S_BR_T5;
         S_BR_T5:  state_d = S_BR_T6;
         S_LDI_T5, S_LD_T7, S_ST_T7, S_R_T5, S_I_T5, S_BR_T6, S_JR_T3:
                   state_d = boundary;
         default:  state_d = S_RESET;
      endcase
   end

   // Output decode of the next state, registered alongside it so that the
   // outputs are a clean function of state_q.
   always_comb begin
      ctrl_d     = '0;
      ctrl_d.run = (state_d != S_RESET) && (state_d != S_HALT);
      case (state_d)
         S_T0: begin ctrl_d.pc_out = 1'b1; ctrl_d.mar_in = 1'b1; ctrl_d.inc_pc = 1'b1; end
         S_T1, S_LD_T6: begin
            ctrl_d.read = 1'b1; ctrl_d.ram_enable = 1'b1; ctrl_d.mdr_in = 1'b1;
         end
         S_T2: begin ctrl_d.mdr_out = 1'b1; ctrl_d.ir_in = 1'b1; end
         S_LDI_T3, S_LD_T3, S_ST_T3: begin
            ctrl_d.grb = 1'b1; ctrl_d.ba_out = 1'b1; ctrl_d.y_in = 1'b1;
         end
         S_LDI_T4, S_LD_T4, S_ST_T4, S_BR_T5: begin
            ctrl_d.c_out = 1'b1; ctrl_d.zlo_in = 1'b1; ctrl_d.alu = ADD_CODE;
         end
         // ZSelect stays 0 to pick the immediate path through the Z mux.
         S_LDI_T5: begin
            ctrl_d.zmux_enable = 1'b1; ctrl_d.zmux_out = 1'b1;
            ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1;
         end
         S_LD_T5, S_ST_T5: begin ctrl_d.zlo_out = 1'b1; ctrl_d.mar_in = 1'b1; end
         S_LD_T7: begin ctrl_d.mdr_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
         // read=0 makes MDR load from the bus rather than from memory.
         S_ST_T6: begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.mdr_in = 1'b1; end
         S_ST_T7: begin ctrl_d.write = 1'b1; ctrl_d.ram_enable = 1'b1; end
         S_R_T3, S_I_T3: begin ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1; end
         S_R_T4: begin
            ctrl_d.grc = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.zlo_in = 1'b1;
            ctrl_d.alu = 5'(op_d);
         end
         S_I_T4: begin
            ctrl_d.c_out = 1'b1; ctrl_d.zlo_in = 1'b1;
            case (op_d)
               OP_ADDI: ctrl_d.alu = 5'b00011;
               OP_ANDI: ctrl_d.alu = 5'b00101;
               OP_ORI:  ctrl_d.alu = 5'b00110;
               default: ctrl_d.alu = 5'b00000;
            endcase
         end
         S_R_T5, S_I_T5: begin ctrl_d.zlo_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
         S_BR_T3: begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.con_in = 1'b1; end
         S_BR_T4: begin ctrl_d.pc_out = 1'b1; ctrl_d.y_in = 1'b1; end
         S_JR_T3: begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.pc_in = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(negedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_RESET;
         op_q    <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // The taken-branch strobes follow CON live during br T6.
   assign br_take = (state_q == S_BR_T6) && CON;

   assign run        = ctrl_q.run;
   assign PCout      = ctrl_q.pc_out;
   assign IncPC      = ctrl_q.inc_pc;
   assign MARin      = ctrl_q.mar_in;
   assign PCin       = ctrl_q.pc_in | br_take;
   assign MDRin      = ctrl_q.mdr_in;
   assign MDRout     = ctrl_q.mdr_out;
   assign IRin       = ctrl_q.ir_in;
   assign Yin        = ctrl_q.y_in;
   assign ZLOin      = ctrl_q.zlo_in;
   assign ZLOout     = ctrl_q.zlo_out | br_take;
   assign Cout       = ctrl_q.c_out;
   assign read       = ctrl_q.read;
   assign write      = ctrl_q.write;
   assign RAMenable  = ctrl_q.ram_enable;
   assign Gra        = ctrl_q.gra;
   assign Grb        = ctrl_q.grb;
   assign Grc        = ctrl_q.grc;
   assign Rin        = ctrl_q.r_in;
   assign Rout       = ctrl_q.r_out;
   assign BAout      = ctrl_q.ba_out;
   assign conin      = ctrl_q.con_in;
   assign ZMuxEnable = ctrl_q.zmux_enable;
   assign ZSelect    = ctrl_q.zselect;
   assign ZMuxOut    = ctrl_q.zmux_out;
   assign aluControl = ctrl_q.alu;
   assign state_dbg  = state_q;

endmodule
